// File: rtl/sr_drive_debounce_pkg.sv
// Shared definitions for the SR latch drive front end: FSM state codes and
// a width helper used to size the debounce and pulse counters.
package sr_drive_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SET_PULSE = 3'd1;
    localparam logic [2:0] ST_RST_PULSE = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_CONFLICT  = 3'd4;

    // Bits needed to count 0..value-1; never less than 1 so a counter always exists.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sr_drive_debounce_if.sv
// Pushbutton-side inputs and latch-side outputs of the drive stage.
// The driver of the raw buttons uses master; the drive stage itself uses slave.
interface sr_drive_debounce_if;
    logic s_raw;
    logic r_raw;
    logic s;
    logic r;
    logic s_db;
    logic r_db;
    logic conflict;

    modport master (
        output s_raw, r_raw,
        input  s, r, s_db, r_db, conflict
    );

    modport slave (
        input  s_raw, r_raw,
        output s, r, s_db, r_db, conflict
    );
endinterface

// File: rtl/sr_drive_debounce_ch.sv
// One input channel: multi-flop synchroniser followed by a counter-based
// debouncer. A new level is accepted only after DEBOUNCE_CYCLES consecutive
// disagreeing cycles; acceptance of a rising level also pulses rise for one cycle.
module debounce_ch
    import sr_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain, newest sample at bit 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Count consecutive mismatches; the counter clears on the accepting cycle so it cannot wrap.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        if (sync_out == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d   = sync_out;
            cnt_d  = '0;
            rise_d = sync_out;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // All channel state clears asynchronously so no stale edge survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
        end
    end

    assign db   = db_q;
    assign rise = rise_q;

endmodule

// File: rtl/sr_drive_debounce.sv
// Drive stage for an SR NOR latch: two debounced button channels feed an
// arbitration FSM that turns accepted rising edges into fixed-width s/r
// pulses, separated by a gap cycle so s and r are never high together.
module sr_drive_debounce
    import sr_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_W         = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_drive_debounce_if.slave   bus
);

    localparam int              PW_W    = clog2(PULSE_W);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_W - 1);

    logic            s_db, r_db, s_rise, r_rise;
    logic [2:0]      state_q, state_d;
    logic [PW_W-1:0] pcnt_q, pcnt_d;
    logic            pend_s_q, pend_s_d;
    logic            pend_r_q, pend_r_d;
    logic            s_q, s_d;
    logic            r_q, r_d;

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_s_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.s_raw),
        .db    (s_db),
        .rise  (s_rise)
    );

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_r_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.r_raw),
        .db    (r_db),
        .rise  (r_rise)
    );

    // State, pulse counter, pending requests and latch drive registers; reset drops s/r at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            pend_s_q <= 1'b0;
            pend_r_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            pend_s_q <= pend_s_d;
            pend_r_q <= pend_r_d;
            s_q      <= s_d;
            r_q      <= r_d;
        end
    end

    // Arbitrate between channels, time the pulse and remember opposite-channel requests.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        pend_s_d = pend_s_q;
        pend_r_d = pend_r_q;
        case (state_q)
            ST_IDLE: begin
                pcnt_d = '0;
                if (s_rise && r_rise) begin
                    state_d  = ST_CONFLICT;
                    pend_s_d = 1'b0;
                    pend_r_d = 1'b0;
                end else if (pend_s_q || s_rise) begin
                    state_d  = ST_SET_PULSE;
                    pend_s_d = 1'b0;
                    if (r_rise) begin
                        pend_r_d = 1'b1;
                    end
                end else if (pend_r_q || r_rise) begin
                    state_d  = ST_RST_PULSE;
                    pend_r_d = 1'b0;
                end
            end
            ST_SET_PULSE: begin
                if (r_rise) begin
                    pend_r_d = 1'b1;
                end
                if (pcnt_q == PW_LAST) begin
                    state_d = ST_GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW_W'(1);
                end
            end
            ST_RST_PULSE: begin
                if (s_rise) begin
                    pend_s_d = 1'b1;
                end
                if (pcnt_q == PW_LAST) begin
                    state_d = ST_GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW_W'(1);
                end
            end
            ST_GAP: begin
                if (s_rise) begin
                    pend_s_d = 1'b1;
                end
                if (r_rise) begin
                    pend_r_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_CONFLICT: begin
                pend_s_d = 1'b0;
                pend_r_d = 1'b0;
                if (!s_db && !r_db) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pcnt_d   = '0;
                pend_s_d = 1'b0;
                pend_r_d = 1'b0;
            end
        endcase
    end

    // Latch drive follows the state being entered, so s/r are registered Moore outputs.
    always_comb begin
        s_d = (state_d == ST_SET_PULSE);
        r_d = (state_d == ST_RST_PULSE);
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.s_db     = s_db;
    assign bus.r_db     = r_db;
    // Lockout is shown only while a debounced level is still high, so it falls with the last one.
    assign bus.conflict = (state_q == ST_CONFLICT) && (s_db || r_db);

endmodule

// File: tb/tb_sr_drive_debounce.sv
// Directed self-checking bench for sr_drive_debounce with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_W=2.
module tb_sr_drive_debounce;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   failCount;

    sr_drive_debounce_if bus ();

    sr_drive_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .PULSE_W         (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 time-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic sVal, input logic rVal);
        bus.s_raw = sVal;
        bus.r_raw = rVal;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] outBundle();
        return {3'b000, bus.s, bus.r, bus.s_db, bus.r_db, bus.conflict};
    endfunction

    // The latch must never see s and r high together.
    always @(negedge clk) begin
        checkOutput("s_r_exclusive", {7'b0, bus.s & bus.r}, 8'h00);
    end

    initial begin
        logic expS;
        logic expR;
        logic expConf;
        int   maxCnt;
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Test 1: held in reset while the buttons chatter, then quiet after release.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c[0], ~c[0]);
            tick();
            checkOutput("t1_in_reset", outBundle(), 8'h00);
        end
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checkOutput("t1_idle_after_release", outBundle(), 8'h00);
        end

        // Test 2: clean set press; s_db after edge 6, s high after edges 7 and 8.
        applyReset();
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            tick();
            checkOutput("t2_s_db", {7'b0, bus.s_db}, {7'b0, (e >= 6)});
            checkOutput("t2_s", {7'b0, bus.s}, {7'b0, (e == 7 || e == 8)});
            checkOutput("t2_r", {7'b0, bus.r}, 8'h00);
        end

        // Test 3: set button bouncing with a 4-cycle period is never accepted.
        applyReset();
        maxCnt = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(((c >> 1) & 1) == 0, 1'b0);
            tick();
            if (int'(dut.u_s_ch.cnt_q) > maxCnt) maxCnt = int'(dut.u_s_ch.cnt_q);
            checkOutput("t3_s_db", {7'b0, bus.s_db}, 8'h00);
            checkOutput("t3_s", {7'b0, bus.s}, 8'h00);
        end
        applyStimulus(1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (int'(dut.u_s_ch.cnt_q) > maxCnt) maxCnt = int'(dut.u_s_ch.cnt_q);
            checkOutput("t3_quiet", outBundle(), 8'h00);
        end
        checkOutput("t3_cnt_max_le2", {7'b0, (maxCnt <= 2)}, 8'h01);

        // Test 4: both buttons together lock the drive out until both are released.
        applyReset();
        applyStimulus(1'b1, 1'b1);
        for (int e = 1; e <= 10; e++) begin
            tick();
            expConf = (e >= 7);
            checkOutput("t4_conflict", {7'b0, bus.conflict}, {7'b0, expConf});
            checkOutput("t4_no_drive", {6'b0, bus.s, bus.r}, 8'h00);
        end
        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            tick();
            expConf = (e <= 5);
            checkOutput("t4_conflict_drop", {7'b0, bus.conflict}, {7'b0, expConf});
            checkOutput("t4_no_pulse", {6'b0, bus.s, bus.r}, 8'h00);
        end

        // Test 5: reset request arrives mid set pulse; it waits for pulse, gap and idle.
        applyReset();
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            if (e == 3) applyStimulus(1'b1, 1'b1);
            tick();
            expS = (e == 7 || e == 8);
            expR = (e == 11 || e == 12);
            checkOutput("t5_s", {7'b0, bus.s}, {7'b0, expS});
            checkOutput("t5_r", {7'b0, bus.r}, {7'b0, expR});
            checkOutput("t5_conflict", {7'b0, bus.conflict}, 8'h00);
        end

        // Test 6: reset during the second pulse cycle drops s before the next edge.
        applyReset();
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick();
        end
        checkOutput("t6_s_before_reset", {7'b0, bus.s}, 8'h01);
        #2;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("t6_s_async_drop", {7'b0, bus.s}, 8'h00);
        checkOutput("t6_outputs_in_reset", outBundle(), 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checkOutput("t6_no_replay", outBundle(), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
